// File: rtl/ncl_ring3_sink.sv
// ncl_ring3_sink: clocked consumer for a 1-of-3 NCL ring source.
// Synchronises the three rails, filters them for stability, runs the
// DATA/NULL completion handshake and decodes and counts tokens.
// Optional rotation checker enabled by defining RING_CHECK_EN.
module ncl_ring3_sink #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic [2:0]       rail,
  input  logic             stall,
  output logic             comp,
  output logic             tok_valid,
  output logic [1:0]       tok_val,
  output logic [CNT_W-1:0] tok_cnt,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] STAB_THR = 3'(STABLE_CYC);

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  logic [2:0]       r_sync [SYNC_STAGES];
  logic [2:0]       w_s;
  logic [2:0]       r_last;
  logic [2:0]       r_stab;
  logic             w_settled;
  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_legal;
  logic [1:0]       w_idx;
  logic             w_tok;
  logic             w_ill;
  logic             w_seq_bad;
  logic             r_tok_valid;
  logic [1:0]       r_tok_val;
  logic [CNT_W-1:0] r_tok_cnt;
  logic             r_err_illegal;
  logic [CNT_W-1:0] r_err_cnt;

  // Per-rail synchroniser chain into the clk domain
  always_ff @(posedge clk) begin
    if (init) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= rail;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Stability filter: r_last is the sampled value, r_stab counts how many
  // consecutive samples it has held (saturating at 7)
  always_ff @(posedge clk) begin
    if (init) begin
      r_last <= '0;
      r_stab <= '0;
    end else begin
      r_last <= w_s;
      if (w_s != r_last)
        r_stab <= 3'd1;
      else if (r_stab != 3'd7)
        r_stab <= r_stab + 3'd1;
    end
  end

  assign w_settled = (r_stab >= STAB_THR);

  // Handshake state register
  always_ff @(posedge clk) begin
    if (init) r_state <= WAIT_DATA;
    else      r_state <= w_next;
  end

  // Next-state: acknowledge settled DATA (unless stalled), release on settled NULL
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        if (w_settled && (r_last != 3'b000) && !stall) begin
          w_next   = WAIT_NULL;
          w_accept = 1'b1;
        end
      end
      WAIT_NULL: begin
        if (w_settled && (r_last == 3'b000)) w_next = WAIT_DATA;
      end
      default: w_next = WAIT_DATA;
    endcase
  end

  // Token decode of the settled wavefront
  always_comb begin
    w_legal = 1'b0;
    w_idx   = 2'd0;
    case (r_last)
      3'b001: begin w_legal = 1'b1; w_idx = 2'd0; end
      3'b010: begin w_legal = 1'b1; w_idx = 2'd1; end
      3'b100: begin w_legal = 1'b1; w_idx = 2'd2; end
      default: begin w_legal = 1'b0; w_idx = 2'd0; end
    endcase
  end

  assign w_tok = w_accept && w_legal;
  assign w_ill = w_accept && !w_legal;

`ifdef RING_CHECK_EN
  logic [1:0] r_ref;
  logic       r_ref_vld;
  logic [1:0] w_ref_next;
  logic       r_err_seq;

  assign w_ref_next = (r_ref == 2'd2) ? 2'd0 : r_ref + 2'd1;
  assign w_seq_bad  = w_tok && r_ref_vld && (w_idx != w_ref_next);

  // Rotation reference: always follows the last legal token
  always_ff @(posedge clk) begin
    if (init) begin
      r_ref     <= '0;
      r_ref_vld <= 1'b0;
      r_err_seq <= 1'b0;
    end else begin
      r_err_seq <= w_seq_bad;
      if (w_tok) begin
        r_ref     <= w_idx;
        r_ref_vld <= 1'b1;
      end
    end
  end

  assign err_seq = r_err_seq;
`else
  assign w_seq_bad = 1'b0;
  assign err_seq   = 1'b0;
`endif

  // Token/error pulses and counters
  always_ff @(posedge clk) begin
    if (init) begin
      r_tok_valid   <= 1'b0;
      r_tok_val     <= '0;
      r_tok_cnt     <= '0;
      r_err_illegal <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_tok_valid   <= w_tok;
      r_err_illegal <= w_ill;
      if (w_tok) begin
        r_tok_val <= w_idx;
        r_tok_cnt <= r_tok_cnt + 1'b1;
      end
      if ((w_ill || w_seq_bad) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign comp        = (r_state == WAIT_NULL);
  assign tok_valid   = r_tok_valid;
  assign tok_val     = r_tok_val;
  assign tok_cnt     = r_tok_cnt;
  assign err_illegal = r_err_illegal;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_ncl_ring3_sink.sv
// Directed table-driven bench for ncl_ring3_sink (CNT_W=4 so wrap and
// saturation are reachable). err_seq expectations depend on RING_CHECK_EN.
module tb_ncl_ring3_sink;

  localparam int unsigned W = 4;
`ifdef RING_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         init = 1'b1;
  logic [2:0]   rail = 3'b000;
  logic         stall = 1'b0;
  logic         comp;
  logic         tok_valid;
  logic [1:0]   tok_val;
  logic [W-1:0] tok_cnt;
  logic         err_illegal;
  logic         err_seq;
  logic [W-1:0] err_cnt;

  ncl_ring3_sink #(.SYNC_STAGES(2), .STABLE_CYC(1), .CNT_W(W)) dut (
    .clk(clk), .init(init), .rail(rail), .stall(stall),
    .comp(comp), .tok_valid(tok_valid), .tok_val(tok_val), .tok_cnt(tok_cnt),
    .err_illegal(err_illegal), .err_seq(err_seq), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // One row: drive inputs, run 'hold' edges; outputs change/pulse at edge 'lat'
  typedef struct {
    logic       init;
    logic [2:0] rail;
    logic       stall;
    int         hold;
    int         lat;
    logic       comp;
    logic       tv;
    logic [1:0] val;
    logic       ill;
    logic       seq;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Expected-state model
  logic       m_comp = 1'b0;
  int         m_tok  = 0;
  int         m_err  = 0;
  logic [1:0] m_val  = 2'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic in_init, input logic [2:0] r, input logic st,
                              input int hold, input int lat, input logic c, input logic tv,
                              input logic [1:0] val, input logic ill, input logic seq);
    vec_t v;
    v.init = in_init; v.rail = r; v.stall = st; v.hold = hold; v.lat = lat;
    v.comp = c; v.tv = tv; v.val = val; v.ill = ill; v.seq = seq;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic prev_c;
    logic seq_eff;
    logic exp_c;
    prev_c  = m_comp;
    seq_eff = SEQ_EN && v.seq;
    init  = v.init;
    rail  = v.rail;
    stall = v.stall;
    for (int e = 1; e <= v.hold; e++) begin
      @(posedge clk);
      #1;
      exp_c = (v.lat != 0 && e >= v.lat) ? v.comp : prev_c;
      chk("comp", int'(comp), int'(exp_c));
      chk("tok_valid", int'(tok_valid), int'(v.tv && e == v.lat));
      chk("err_illegal", int'(err_illegal), int'(v.ill && e == v.lat));
      chk("err_seq", int'(err_seq), int'(seq_eff && e == v.lat));
      if (v.tv && e == v.lat) chk("tok_val_pulse", int'(tok_val), int'(v.val));
    end
    if (v.init) begin
      m_tok = 0; m_err = 0; m_val = 2'd0;
    end else begin
      if (v.tv) begin
        m_tok = (m_tok + 1) % 16;
        m_val = v.val;
      end
      if ((v.ill || seq_eff) && m_err != 15) m_err++;
    end
    m_comp = v.comp;
    chk("tok_cnt", int'(tok_cnt), m_tok);
    chk("err_cnt", int'(err_cnt), m_err);
    chk("tok_val", int'(tok_val), int'(m_val));
  endtask

  initial begin
    // reset, rotation 0,1,2 with a DATA->DATA change inside the first token
    tbl.push_back(mk(1, 3'b000, 0,  3, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 0,  8, 4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0,  8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0,  8, 4, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 0,  8, 4, 1, 1, 2, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    // stalled DATA, released after 20 cycles (breaks rotation: ref 2 -> got 1)
    tbl.push_back(mk(0, 3'b010, 1, 20, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0,  8, 1, 1, 1, 1, 0, 1));
    // NULL accepted even with stall high
    tbl.push_back(mk(0, 3'b000, 1,  8, 4, 0, 0, 0, 0, 0));
    // illegal code still acknowledged
    tbl.push_back(mk(0, 3'b011, 0,  8, 4, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 0,  8, 4, 1, 1, 2, 0, 0));
    // reset mid-handshake, then the held 100 is a fresh first token
    tbl.push_back(mk(1, 3'b100, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 0,  8, 4, 1, 1, 2, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    // rotation check 0,1,0,1 from reset: third token out of order
    tbl.push_back(mk(1, 3'b000, 0,  2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 0,  8, 4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0,  8, 4, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 0,  8, 4, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0,  8, 4, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0,  8, 4, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // tok_cnt wrap: 17 rotating tokens from reset
    apply(mk(1, 3'b000, 0, 2, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 17; i++) begin
      apply(mk(0, 3'(1 << (i % 3)), 0, 6, 4, 1, 1, 2'(i % 3), 0, 0));
      apply(mk(0, 3'b000, 0, 6, 4, 0, 0, 0, 0, 0));
    end
    chk("tok_cnt_wrap", int'(tok_cnt), 1);

    // err_cnt saturation: 20 illegal wavefronts
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 3'b110, 0, 6, 4, 1, 0, 0, 1, 0));
      apply(mk(0, 3'b000, 0, 6, 4, 0, 0, 0, 0, 0));
    end
    chk("err_cnt_sat", int'(err_cnt), 15);
    chk("tok_cnt_after_sat", int'(tok_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ncl_ring3_sink.md
Name: ncl_ring3_sink

Overview:
- Clocked consumer for a 1-of-3 (three-rail) NCL ring source. It closes the source's completion loop.
- Synchronises the three asynchronous rails into the clock domain and detects DATA and NULL wavefronts.
- Drives the completion (acknowledge) back to the source, decodes each token and checks the 0->1->2->0 rail rotation the source produces.
- Sits at the boundary between the self-timed steering sandbox and clocked test and measurement logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the per-rail synchroniser (minimum 2).
- STABLE_CYC, 1, consecutive identical synchronised samples required before a wavefront is accepted (1..7).
- CNT_W, 16, width of the token and error counters.

Ports:
- clk  in  1  system clock.
- init  in  1  reset; synchronous, active-high.
- rail  in  3  asynchronous 1-of-3 data from the ring source; 000 = NULL.
- stall  in  1  back-pressure; while high, a DATA wavefront is not acknowledged.
- comp  out  1  completion to the source (source TCOMP input). 1 = DATA received, request NULL. 0 = request DATA.
- tok_valid  out  1  one-cycle pulse per accepted legal token.
- tok_val  out  2  rail index of the last accepted token (0,1,2).
- tok_cnt  out  CNT_W  accepted legal tokens; wraps.
- err_illegal  out  1  one-cycle pulse: accepted wavefront had more than one rail high.
- err_seq  out  1  one-cycle pulse: token broke the rotation (RING_CHECK_EN only; otherwise tied 0).
- err_cnt  out  CNT_W  total error pulses; saturates at all-ones.

Behaviour:
- Reset (init high at a clk edge): all synchroniser flops 0; comp=0; tok_valid=0; tok_val=0; tok_cnt=0; err_illegal=0; err_seq=0; err_cnt=0; stability counter 0; FSM in WAIT_DATA; sequence reference cleared.
- Reset mid-handshake: comp drops on the reset edge. After reset, any DATA still present is accepted as a fresh first token.
- Synchroniser: each rail passes through SYNC_STAGES flops; s = last stage.
- Stability filter: a value of s is "settled" once it has been identical for STABLE_CYC consecutive cycles. Any change restarts the count.
- State WAIT_DATA (comp=0):
  - On settled s != 000 with stall=0: on the next edge go to WAIT_NULL and set comp=1.
  - On that same edge, a legal one-hot s gives tok_valid=1, tok_val=index, tok_cnt+1.
  - On that same edge, an illegal s (2 or 3 rails high) gives err_illegal=1 and err_cnt+1; tok_val and tok_cnt are unchanged.
  - Illegal codes are still acknowledged so the ring keeps running.
  - Settled DATA with stall=1: remain in WAIT_DATA, comp stays 0. The token is evaluated only when stall falls, if s is still settled nonzero.
- State WAIT_NULL (comp=1): on settled s == 000, next edge go to WAIT_DATA and set comp=0. stall is ignored in this state.
- Latency: a rail edge arriving before clk edge k gives the comp change at edge k+SYNC_STAGES+STABLE_CYC-1+1 (4 edges with defaults), unless stalled.
- tok_valid, err_illegal and err_seq are high for exactly one cycle per wavefront; they never repeat while DATA is held.
- A DATA->different DATA transition with no intervening NULL is not a wavefront. s stays nonzero, the FSM remains in WAIT_NULL and no token is counted.
- err_cnt adds +1 per cycle in which err_illegal or err_seq is high (+1 even if both are high). It saturates and holds at 2^CNT_W-1.
- tok_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro RING_CHECK_EN.
- When defined:
  - A reference register holds the previous legal token index.
  - The first legal token after reset only loads the reference.
  - Each later legal token is compared with (ref+1) mod 3. On mismatch, err_seq pulses with tok_valid and err_cnt increments.
  - The reference always updates to the received index, so checking resynchronises after a single error.
  - Illegal codes do not touch the reference.
- When undefined: no reference logic; err_seq is constant 0.

Test Plan:
- Reset then rail sequence 001,000,010,000,100,000, each held 10 cycles, defaults -> comp follows with 4-edge latency; tok_val 0,1,2; tok_cnt=3; err_cnt=0.
- Rail=010 with stall=1 for 20 cycles, then stall=0 -> comp stays 0 throughout the stall; comp=1 and tok_valid pulse on the edge after stall falls; exactly one tok_valid.
- Rail=011 then 000 -> err_illegal one pulse; comp 0->1->0; tok_cnt unchanged; err_cnt=1.
- RING_CHECK_EN defined, tokens 0,1,0,1 with NULLs between -> err_seq pulses on the 3rd token only (expected 2, got 0); the 4th token is clean; err_cnt=1.
- init asserted for 1 cycle while comp=1 and rail=100 -> comp=0 on the reset edge; 100 is re-accepted as the first token (comp=1 after 4 edges); tok_cnt=1; no err_seq.
- CNT_W=4, 17 legal rotating tokens -> tok_cnt wraps to 1. Then 20 illegal 110/000 pairs -> err_cnt saturates at 15.
